// File: rtl/wb_queue.sv
// wb_queue: write-back queue between execute/LSU results and the regfile write port.
// Optional WB_BYPASS_EN forwards the youngest pending value instead of flagging RAW hazards.
module wb_queue #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    Wrclk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDR_WIDTH-1:0]   in_rd,
    input  logic [DATA_WIDTH-1:0]   in_data,
    input  logic                    wb_hold,
    input  logic                    flush,
    output logic [ADDR_WIDTH-1:0]   Rw,
    output logic [DATA_WIDTH-1:0]   busW,
    output logic                    RegWr,
    input  logic [ADDR_WIDTH-1:0]   Ra,
    input  logic [ADDR_WIDTH-1:0]   Rb,
    input  logic [DATA_WIDTH-1:0]   busA,
    input  logic [DATA_WIDTH-1:0]   busB,
    output logic [DATA_WIDTH-1:0]   opA,
    output logic [DATA_WIDTH-1:0]   opB,
    output logic                    hzdA,
    output logic                    hzdB,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [ADDR_WIDTH-1:0] r_rd   [DEPTH];
    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]      r_vld;
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_store;
    logic                  w_pop;
    logic [PW-1:0]         w_scan;
    logic                  w_hit_a;
    logic                  w_hit_b;

    // Handshake: a result transfers on a rising edge where in_valid && in_ready; in_ready
    // depends only on registered occupancy, so it never combinationally follows in_valid.
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == FULL_CNT);
    assign in_ready = !w_full;
    assign w_push   = in_valid && in_ready && !flush;
    assign w_store  = w_push && (in_rd != '0);
    assign w_pop    = !w_empty && !wb_hold && !flush;

    assign RegWr = w_pop;
    assign Rw    = w_empty ? '0 : r_rd[r_rd_ptr];
    assign busW  = w_empty ? '0 : r_data[r_rd_ptr];
    assign count = r_count;

    always_ff @(posedge Wrclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vld    <= '0;
        end else begin
            if (w_store) begin
                r_vld[r_wr_ptr] <= 1'b1;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_vld[r_rd_ptr] <= 1'b0;
                r_rd_ptr        <= r_rd_ptr + 1'b1;
            end
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload needs no reset: valid bits and the empty mux hide stale contents.
    always_ff @(posedge Wrclk) begin
        if (w_store) begin
            r_rd[r_wr_ptr]   <= in_rd;
            r_data[r_wr_ptr] <= in_data;
        end
    end

    // The head is still compared: it commits at the same edge the regfile is read.
    always_comb begin
        w_hit_a = 1'b0;
        w_hit_b = 1'b0;
        w_scan  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_scan = r_rd_ptr + PW'(i);
            if (r_vld[w_scan] && (Ra != '0) && (r_rd[w_scan] == Ra)) begin
                w_hit_a = 1'b1;
            end
            if (r_vld[w_scan] && (Rb != '0) && (r_rd[w_scan] == Rb)) begin
                w_hit_b = 1'b1;
            end
        end
    end

`ifdef WB_BYPASS_EN
    logic [PW-1:0]         w_fscan;
    logic [DATA_WIDTH-1:0] w_fwd_a;
    logic [DATA_WIDTH-1:0] w_fwd_b;

    // Scan oldest to youngest so the youngest matching entry overrides older ones.
    always_comb begin
        w_fwd_a = busA;
        w_fwd_b = busB;
        w_fscan = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_fscan = r_rd_ptr + PW'(i);
            if (r_vld[w_fscan] && (Ra != '0) && (r_rd[w_fscan] == Ra)) begin
                w_fwd_a = r_data[w_fscan];
            end
            if (r_vld[w_fscan] && (Rb != '0) && (r_rd[w_fscan] == Rb)) begin
                w_fwd_b = r_data[w_fscan];
            end
        end
    end

    assign opA  = w_hit_a ? w_fwd_a : busA;
    assign opB  = w_hit_b ? w_fwd_b : busB;
    assign hzdA = 1'b0;
    assign hzdB = 1'b0;
`else
    assign opA  = busA;
    assign opB  = busB;
    assign hzdA = w_hit_a;
    assign hzdB = w_hit_b;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed vectors, write-back scoreboard and
// direct checks of occupancy, handshake and operand outputs.
module tb_wb_queue;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    logic          Wrclk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_rd;
    logic [DW-1:0] in_data;
    logic          wb_hold;
    logic          flush;
    logic [AW-1:0] Rw;
    logic [DW-1:0] busW;
    logic          RegWr;
    logic [AW-1:0] Ra;
    logic [AW-1:0] Rb;
    logic [DW-1:0] busA;
    logic [DW-1:0] busB;
    logic [DW-1:0] opA;
    logic [DW-1:0] opB;
    logic          hzdA;
    logic          hzdB;
    logic [2:0]    count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [AW+DW-1:0] exp_q [$];

    wb_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .Wrclk(Wrclk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_data(in_data), .wb_hold(wb_hold), .flush(flush),
        .Rw(Rw), .busW(busW), .RegWr(RegWr), .Ra(Ra), .Rb(Rb),
        .busA(busA), .busB(busB), .opA(opA), .opB(opB),
        .hzdA(hzdA), .hzdB(hzdB), .count(count)
    );

    // clock / reset
    initial begin
        Wrclk = 1'b0;
        forever #5 Wrclk = ~Wrclk;
    end

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // driver tasks (called at posedge+1)
    task automatic push(input logic [AW-1:0] rd, input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_rd    = rd;
        in_data  = d;
        @(posedge Wrclk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge Wrclk);
        #1;
    endtask

    // scoreboard monitor: every regfile write must match the oldest expected entry
    always @(negedge Wrclk) begin
        if (rst_n && RegWr) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got Rw=%0d busW=0x%0h, expected no write", Rw, busW);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                if ({Rw, busW} !== e) begin
                    n_fail++;
                    $display("FAIL wb_order: got Rw=%0d busW=0x%0h, expected Rw=%0d busW=0x%0h",
                             Rw, busW, e[AW+DW-1:DW], e[DW-1:0]);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_data = '0;
        wb_hold = 1'b0; flush = 1'b0; Ra = '0; Rb = '0;
        busA = 32'h5A5A; busB = 32'hA5A5;
        cycles(2);
        rst_n = 1'b1;
        cycles(1);

        // reset state
        check("rst_count", DW'(count), 0);
        check("rst_ready", DW'(in_ready), 1);
        check("rst_regwr", DW'(RegWr), 0);
        check("rst_rw", DW'(Rw), 0);
        check("rst_busw", busW, 0);
        check("rst_hzda", DW'(hzdA), 0);
        check("rst_opa", opA, 32'h5A5A);
        check("rst_opb", opB, 32'hA5A5);

        // 1: asynchronous reset mid-cycle drops pending entries
        wb_hold = 1'b1;
        push(5'd3, 32'h33);
        push(5'd4, 32'h44);
        check("t1_count_pre", DW'(count), 2);
        wb_hold = 1'b0;
        #1;
        check("t1_regwr_pre", DW'(RegWr), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t1_count_async", DW'(count), 0);
        check("t1_regwr_async", DW'(RegWr), 0);
        check("t1_ready_async", DW'(in_ready), 1);
        check("t1_rw_async", DW'(Rw), 0);
        cycles(1);
        rst_n = 1'b1;
        cycles(1);

        // 2: single push drains one cycle later
        exp_q.push_back({5'd5, 32'h1234});
        push(5'd5, 32'h1234);
        check("t2_regwr", DW'(RegWr), 1);
        check("t2_rw", DW'(Rw), 5);
        check("t2_busw", busW, 32'h1234);
        check("t2_count", DW'(count), 1);
        cycles(1);
        check("t2_count_after", DW'(count), 0);
        check("t2_regwr_after", DW'(RegWr), 0);

        // 3: fill under hold (pointers wrap), fifth push refused, FIFO drain
        wb_hold = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back({AW'(i), DW'(i * 32'h11)});
            push(AW'(i), DW'(i * 32'h11));
        end
        check("t3_count_full", DW'(count), 4);
        check("t3_ready_full", DW'(in_ready), 0);
        check("t3_regwr_hold", DW'(RegWr), 0);
        push(5'd9, 32'h99);
        check("t3_count_5th", DW'(count), 4);
        wb_hold = 1'b0;
        #1;
        check("t3_ready_popping", DW'(in_ready), 0);
        cycles(5);
        check("t3_count_drained", DW'(count), 0);
        check("t3_q_drained", DW'(exp_q.size()), 0);

        // 4: x0 results are accepted but never written
        push(5'd0, 32'hFFFF);
        check("t4_count", DW'(count), 0);
        check("t4_regwr", DW'(RegWr), 0);
        cycles(2);

        // 5: same rd twice, youngest must win; Rb unmatched; Ra=0 never matches
        wb_hold = 1'b1;
        exp_q.push_back({5'd7, 32'hA});
        exp_q.push_back({5'd7, 32'hB});
        push(5'd7, 32'hA);
        push(5'd7, 32'hB);
        Ra = 5'd7; busA = 32'h0;
        Rb = 5'd3; busB = 32'h55;
        #1;
`ifdef WB_BYPASS_EN
        check("t5_opa", opA, 32'hB);
        check("t5_hzda", DW'(hzdA), 0);
`else
        check("t5_opa", opA, 32'h0);
        check("t5_hzda", DW'(hzdA), 1);
`endif
        check("t5_opb", opB, 32'h55);
        check("t5_hzdb", DW'(hzdB), 0);
        Ra = 5'd0; busA = 32'h77;
        #1;
        check("t5_opa_x0", opA, 32'h77);
        check("t5_hzda_x0", DW'(hzdA), 0);
        wb_hold = 1'b0;
        cycles(3);
        check("t5_count_drained", DW'(count), 0);

        // 6: flush discards pending entries, blocks the write and drops a same-cycle push
        wb_hold = 1'b1;
        push(5'd10, 32'h1010);
        push(5'd11, 32'h1111);
        push(5'd12, 32'h1212);
        check("t6_count_pre", DW'(count), 3);
        wb_hold = 1'b0;
        flush = 1'b1;
        in_valid = 1'b1; in_rd = 5'd8; in_data = 32'h88;
        #1;
        check("t6_regwr_flush", DW'(RegWr), 0);
        cycles(1);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("t6_count_after", DW'(count), 0);
        check("t6_regwr_after", DW'(RegWr), 0);
        check("t6_ready_after", DW'(in_ready), 1);
        cycles(3);
        check("t6_count_idle", DW'(count), 0);

        check("end_q_empty", DW'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
